// File: rtl/conv_stream_if.sv
// Handshake and status bundle between the layer sequencer and its DMA stream,
// kernel BRAM, datapath and host control.
interface conv_stream_if;
    logic        start;
    logic [1:0]  CHANNEL_SIZE_choose;
    logic [2:0]  IMAGE_SIZE_choose;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        pix_ready;
    logic        out_last;
    logic        kernel_we;
    logic [7:0]  kernel_addr;
    logic        pix_valid;
    logic [7:0]  pix_chan;
    logic [11:0] pix_index;
    logic [11:0] bias_addr;
    logic        busy;
    logic        conv_DONE;
    logic        err_cfg;
    logic        err_tlast_early;
    logic        err_tlast_missing;

    modport master (
        output start, CHANNEL_SIZE_choose, IMAGE_SIZE_choose,
        output s_axis_tvalid, s_axis_tlast, pix_ready, out_last,
        input  s_axis_tready, kernel_we, kernel_addr, pix_valid, pix_chan, pix_index,
        input  bias_addr, busy, conv_DONE, err_cfg, err_tlast_early, err_tlast_missing
    );

    modport slave (
        input  start, CHANNEL_SIZE_choose, IMAGE_SIZE_choose,
        input  s_axis_tvalid, s_axis_tlast, pix_ready, out_last,
        output s_axis_tready, kernel_we, kernel_addr, pix_valid, pix_chan, pix_index,
        output bias_addr, busy, conv_DONE, err_cfg, err_tlast_early, err_tlast_missing
    );
endinterface

// File: rtl/conv_stream_scheduler.sv
// Sequences one convolution output layer: loads C kernel words, streams N*N*C
// image beats channel-fastest, waits for the datapath to drain, then advances bias.
module conv_stream_scheduler (
    input  logic          clk,
    input  logic          aresetn,
    conv_stream_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD_KERNEL, ST_STREAM_IMAGE, ST_DRAIN, ST_DONE
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [1:0]  c_sel_r;
    logic [2:0]  n_sel_r;
    logic [7:0]  kcnt_r;
    logic [19:0] beat_cnt_r;
    logic [7:0]  chan_cnt_r;
    logic [11:0] idx_cnt_r;
    logic [11:0] bias_r;
    logic        abort_r, err_cfg_r, err_early_r, err_missing_r;

    logic [7:0]  c_last_s;
    logic [4:0]  c_log2_s, n_log2_s;
    logic [20:0] total_s;
    logic [19:0] total_m1_s;
    logic        tready_s, accept_s, kernel_we_s, pix_valid_s;
    logic        load_cfg_s, cfg_bad_s, set_early_s, set_missing_s;

    // Decode latched geometry into last-channel index and log2 sizes
    always_comb begin
        case (c_sel_r)
            2'd0:    begin c_last_s = 8'd255; c_log2_s = 5'd8; end
            2'd1:    begin c_last_s = 8'd127; c_log2_s = 5'd7; end
            2'd2:    begin c_last_s = 8'd63;  c_log2_s = 5'd6; end
            2'd3:    begin c_last_s = 8'd31;  c_log2_s = 5'd5; end
            default: begin c_last_s = 8'd255; c_log2_s = 5'd8; end
        endcase
        case (n_sel_r)
            3'd0:    n_log2_s = 5'd2;
            3'd1:    n_log2_s = 5'd3;
            3'd2:    n_log2_s = 5'd4;
            3'd3:    n_log2_s = 5'd5;
            3'd4:    n_log2_s = 5'd6;
            default: n_log2_s = 5'd2;
        endcase
    end

    // N*N*C is always a power of two, so the final image beat index is 2^k - 1
    assign total_s    = (21'd1 << (n_log2_s + n_log2_s + c_log2_s)) - 21'd1;
    assign total_m1_s = total_s[19:0];

    assign tready_s    = (state_r == ST_LOAD_KERNEL) ? 1'b1 :
                         (state_r == ST_STREAM_IMAGE) ? bus.pix_ready : 1'b0;
    assign accept_s    = bus.s_axis_tvalid & tready_s;
    assign kernel_we_s = accept_s & (state_r == ST_LOAD_KERNEL);
    assign pix_valid_s = accept_s & (state_r == ST_STREAM_IMAGE);

    // Next-state and one-cycle control strobes
    always_comb begin
        state_nxt_s   = state_r;
        load_cfg_s    = 1'b0;
        cfg_bad_s     = 1'b0;
        set_early_s   = 1'b0;
        set_missing_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && (bus.IMAGE_SIZE_choose <= 3'd4)) begin
                    load_cfg_s  = 1'b1;
                    state_nxt_s = ST_LOAD_KERNEL;
                end else if (bus.start) begin
                    cfg_bad_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD_KERNEL: begin
                if (accept_s && bus.s_axis_tlast) begin
                    set_early_s = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else if (accept_s && (kcnt_r == c_last_s)) begin
                    state_nxt_s = ST_STREAM_IMAGE;
                end else begin
                    state_nxt_s = ST_LOAD_KERNEL;
                end
            end
            ST_STREAM_IMAGE: begin
                if (accept_s && (beat_cnt_r == total_m1_s)) begin
                    set_missing_s = ~bus.s_axis_tlast;
                    state_nxt_s   = ST_DRAIN;
                end else if (accept_s && bus.s_axis_tlast) begin
                    set_early_s = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_STREAM_IMAGE;
                end
            end
            ST_DRAIN: begin
                if (abort_r || bus.out_last) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Geometry latch, beat counters and sticky error flags
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            c_sel_r <= 2'd0;  n_sel_r <= 3'd0;  kcnt_r <= 8'd0;
            beat_cnt_r <= 20'd0;  chan_cnt_r <= 8'd0;  idx_cnt_r <= 12'd0;
            abort_r <= 1'b0;  err_cfg_r <= 1'b0;  err_early_r <= 1'b0;  err_missing_r <= 1'b0;
        end else if (load_cfg_s) begin
            c_sel_r <= bus.CHANNEL_SIZE_choose;  n_sel_r <= bus.IMAGE_SIZE_choose;
            kcnt_r <= 8'd0;  beat_cnt_r <= 20'd0;  chan_cnt_r <= 8'd0;  idx_cnt_r <= 12'd0;
            abort_r <= 1'b0;  err_cfg_r <= 1'b0;  err_early_r <= 1'b0;  err_missing_r <= 1'b0;
        end else begin
            if (cfg_bad_s)     err_cfg_r <= 1'b1;
            if (kernel_we_s)   kcnt_r <= kcnt_r + 8'd1;
            if (pix_valid_s) begin
                beat_cnt_r <= beat_cnt_r + 20'd1;
                if (chan_cnt_r == c_last_s) begin
                    chan_cnt_r <= 8'd0;
                    idx_cnt_r  <= idx_cnt_r + 12'd1;
                end else begin
                    chan_cnt_r <= chan_cnt_r + 8'd1;
                end
            end
            if (set_early_s) begin
                err_early_r <= 1'b1;
                abort_r     <= 1'b1;
            end
            if (set_missing_s) err_missing_r <= 1'b1;
        end
    end

    // Bias pointer advances once per completed layer
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)                bias_r <= 12'd0;
        else if (state_r == ST_DONE) bias_r <= bias_r + 12'd1;
    end

    assign bus.s_axis_tready     = tready_s;
    assign bus.kernel_we         = kernel_we_s;
    assign bus.kernel_addr       = kcnt_r;
    assign bus.pix_valid         = pix_valid_s;
    assign bus.pix_chan          = chan_cnt_r;
    assign bus.pix_index         = idx_cnt_r;
    assign bus.bias_addr         = bias_r;
    assign bus.busy              = (state_r != ST_IDLE);
    assign bus.conv_DONE         = (state_r == ST_DONE);
    assign bus.err_cfg           = err_cfg_r;
    assign bus.err_tlast_early   = err_early_r;
    assign bus.err_tlast_missing = err_missing_r;
endmodule

// File: tb/tb_conv_stream_scheduler.sv
// Directed bench for conv_stream_scheduler: full layers, backpressure, tlast
// errors, bad configuration and mid-run reset, with hand-derived expectations.
module tb_conv_stream_scheduler;
    logic clk = 1'b0;
    logic aresetn;
    conv_stream_if bus();

    conv_stream_scheduler dut (.clk(clk), .aresetn(aresetn), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, bias_exp = 0;
    int kcnt, pcnt, order_err, mirror_err, spur_err, last_chan, last_index;
    int done_cnt, done_cycle, busy_drop;

    task automatic do_start(input logic [1:0] csel, input logic [2:0] nsel);
        @(negedge clk);
        bus.CHANNEL_SIZE_choose = csel;
        bus.IMAGE_SIZE_choose   = nsel;
        bus.start               = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offers up to nbeats stream beats; model: first c are kernel words, then channel-fastest pixels
    task automatic drive_layer(input int c, input int nbeats, input int tlast_at, input bit toggle);
        int beat = 0;
        bit acc, stop = 1'b0;
        kcnt = 0; pcnt = 0; order_err = 0; mirror_err = 0; spur_err = 0;
        last_chan = -1; last_index = -1;
        for (int cyc = 0; cyc < nbeats * 3 + 64 && !stop; cyc++) begin
            bus.pix_ready     = toggle ? (cyc % 2 == 1) : 1'b1;
            bus.s_axis_tvalid = (beat < nbeats);
            bus.s_axis_tlast  = (beat == tlast_at);
            #1;
            acc = bus.s_axis_tvalid && bus.s_axis_tready;
            if (beat >= c && bus.s_axis_tready !== bus.pix_ready) mirror_err++;
            if (bus.conv_DONE !== 1'b0) spur_err++;
            if (!acc && (bus.kernel_we !== 1'b0 || bus.pix_valid !== 1'b0)) spur_err++;
            if (acc) begin
                if (beat < c) begin
                    if (bus.kernel_we !== 1'b1 || bus.pix_valid !== 1'b0 ||
                        bus.kernel_addr !== 8'(beat)) order_err++;
                    kcnt++;
                end else begin
                    if (bus.pix_valid !== 1'b1 || bus.kernel_we !== 1'b0 ||
                        bus.pix_chan !== 8'((beat - c) % c) ||
                        bus.pix_index !== 12'((beat - c) / c)) order_err++;
                    pcnt++;
                    last_chan  = int'(bus.pix_chan);
                    last_index = int'(bus.pix_index);
                end
                if (beat == tlast_at) stop = 1'b1;
                beat++;
                if (beat == nbeats) stop = 1'b1;
            end
            @(negedge clk);
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        if (!stop) begin
            checks++; failures++;
            $display("FAIL stream_timeout beats=%0d required=%0d", beat, nbeats);
        end
    endtask

    // Pulses out_last at cycle `delay` of the drain window and records conv_DONE timing
    task automatic drain(input int delay);
        done_cnt = 0; done_cycle = -1; busy_drop = 0;
        for (int i = 0; i < delay + 8; i++) begin
            bus.out_last = (i == delay);
            #1;
            if (bus.conv_DONE === 1'b1) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = i;
            end
            if (done_cycle < 0 && bus.busy !== 1'b1) busy_drop++;
            @(negedge clk);
        end
        bus.out_last = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        bus.start = 1'b0; bus.CHANNEL_SIZE_choose = 2'd0; bus.IMAGE_SIZE_choose = 3'd0;
        bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0; bus.pix_ready = 1'b0; bus.out_last = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.conv_DONE, bus.s_axis_tready, bus.kernel_we, bus.pix_valid,
             bus.err_cfg, bus.err_tlast_early, bus.err_tlast_missing} !== 8'h00) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000000",
                {bus.busy, bus.conv_DONE, bus.s_axis_tready, bus.kernel_we, bus.pix_valid,
                 bus.err_cfg, bus.err_tlast_early, bus.err_tlast_missing});
        end
        checks++;
        if ({bus.kernel_addr, bus.pix_chan, bus.pix_index, bus.bias_addr} !== 40'd0) begin
            failures++; $display("FAIL reset_buses addr=%0d chan=%0d idx=%0d bias=%0d exp=0",
                bus.kernel_addr, bus.pix_chan, bus.pix_index, bus.bias_addr);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_full_layer();
        do_start(2'd0, 3'd0);
        drive_layer(256, 4352, 4351, 1'b0);
        drain(20);
        bias_exp++;
        checks++; if (kcnt !== 256) begin failures++; $display("FAIL full_kernel_we got=%0d exp=256", kcnt); end
        checks++; if (pcnt !== 4096) begin failures++; $display("FAIL full_pix_valid got=%0d exp=4096", pcnt); end
        checks++; if (order_err !== 0 || spur_err !== 0) begin failures++; $display("FAIL full_order order_err=%0d spur_err=%0d exp=0", order_err, spur_err); end
        checks++; if (last_chan !== 255 || last_index !== 15) begin failures++; $display("FAIL full_last chan=%0d idx=%0d exp=255/15", last_chan, last_index); end
        checks++; if (done_cnt !== 1 || done_cycle !== 21) begin failures++; $display("FAIL full_done count=%0d cycle=%0d exp=1/21", done_cnt, done_cycle); end
        checks++; if (bus.bias_addr !== 12'(bias_exp)) begin failures++; $display("FAIL full_bias got=%0d exp=%0d", bus.bias_addr, bias_exp); end
        checks++; if ({bus.err_cfg, bus.err_tlast_early, bus.err_tlast_missing, bus.busy} !== 4'b0000) begin failures++; $display("FAIL full_flags got=%b exp=0000", {bus.err_cfg, bus.err_tlast_early, bus.err_tlast_missing, bus.busy}); end
    endtask

    task automatic test_backpressure();
        do_start(2'd3, 3'd1);
        drive_layer(32, 2080, 2079, 1'b1);
        drain(5);
        bias_exp++;
        checks++; if (pcnt !== 2048 || kcnt !== 32) begin failures++; $display("FAIL bp_counts pix=%0d kern=%0d exp=2048/32", pcnt, kcnt); end
        checks++; if (mirror_err !== 0) begin failures++; $display("FAIL bp_tready_mirror errors=%0d exp=0", mirror_err); end
        checks++; if (order_err !== 0 || spur_err !== 0) begin failures++; $display("FAIL bp_order order_err=%0d spur_err=%0d exp=0", order_err, spur_err); end
        checks++; if (done_cnt !== 1 || done_cycle !== 6) begin failures++; $display("FAIL bp_done count=%0d cycle=%0d exp=1/6", done_cnt, done_cycle); end
        checks++; if (bus.bias_addr !== 12'(bias_exp)) begin failures++; $display("FAIL bp_bias got=%0d exp=%0d", bus.bias_addr, bias_exp); end
    endtask

    task automatic test_tlast_early();
        do_start(2'd0, 3'd0);
        drive_layer(256, 4352, 10, 1'b0);
        bus.s_axis_tvalid = 1'b1;
        #1;
        checks++; if (bus.s_axis_tready !== 1'b0 || bus.kernel_we !== 1'b0) begin failures++; $display("FAIL early_tready tready=%b we=%b exp=0/0", bus.s_axis_tready, bus.kernel_we); end
        checks++; if (bus.err_tlast_early !== 1'b1 || bus.err_tlast_missing !== 1'b0) begin failures++; $display("FAIL early_flags early=%b missing=%b exp=1/0", bus.err_tlast_early, bus.err_tlast_missing); end
        checks++; if (kcnt !== 11 || pcnt !== 0) begin failures++; $display("FAIL early_counts kern=%0d pix=%0d exp=11/0", kcnt, pcnt); end
        drain(20);
        bus.s_axis_tvalid = 1'b0;
        bias_exp++;
        checks++; if (done_cnt !== 1 || done_cycle !== 1) begin failures++; $display("FAIL early_done count=%0d cycle=%0d exp=1/1", done_cnt, done_cycle); end
        checks++; if (bus.bias_addr !== 12'(bias_exp)) begin failures++; $display("FAIL early_bias got=%0d exp=%0d", bus.bias_addr, bias_exp); end
    endtask

    task automatic test_tlast_missing();
        do_start(2'd1, 3'd0);
        drive_layer(128, 2176, -1, 1'b0);
        checks++; if (bus.err_tlast_missing !== 1'b1 || bus.err_tlast_early !== 1'b0) begin failures++; $display("FAIL missing_flags missing=%b early=%b exp=1/0", bus.err_tlast_missing, bus.err_tlast_early); end
        checks++; if (pcnt !== 2048 || order_err !== 0) begin failures++; $display("FAIL missing_stream pix=%0d order_err=%0d exp=2048/0", pcnt, order_err); end
        drain(20);
        bias_exp++;
        checks++; if (done_cnt !== 1 || done_cycle !== 21 || busy_drop !== 0) begin failures++; $display("FAIL missing_drain count=%0d cycle=%0d busy_drop=%0d exp=1/21/0", done_cnt, done_cycle, busy_drop); end
        checks++; if (bus.bias_addr !== 12'(bias_exp)) begin failures++; $display("FAIL missing_bias got=%0d exp=%0d", bus.bias_addr, bias_exp); end
    endtask

    task automatic test_cfg_error();
        do_start(2'd0, 3'd6);
        checks++; if (bus.err_cfg !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL cfg_reject err_cfg=%b busy=%b exp=1/0", bus.err_cfg, bus.busy); end
        do_start(2'd3, 3'd0);
        checks++; if (bus.err_cfg !== 1'b0 || bus.err_tlast_missing !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL cfg_restart err_cfg=%b missing=%b busy=%b exp=0/0/1", bus.err_cfg, bus.err_tlast_missing, bus.busy); end
        drive_layer(32, 544, 543, 1'b0);
        drain(3);
        bias_exp++;
        checks++; if (done_cnt !== 1 || pcnt !== 512 || bus.bias_addr !== 12'(bias_exp)) begin failures++; $display("FAIL cfg_run done=%0d pix=%0d bias=%0d exp=1/512/%0d", done_cnt, pcnt, bus.bias_addr, bias_exp); end
    endtask

    task automatic test_reset_mid_run();
        do_start(2'd3, 3'd0);
        drive_layer(32, 132, -1, 1'b0);
        bus.s_axis_tvalid = 1'b1;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.s_axis_tready, bus.kernel_we, bus.pix_valid, bus.conv_DONE} !== 5'b00000 ||
            {bus.bias_addr, bus.pix_index, bus.pix_chan} !== 32'd0) begin
            failures++; $display("FAIL midreset_outputs busy=%b tready=%b bias=%0d idx=%0d chan=%0d exp=0",
                bus.busy, bus.s_axis_tready, bus.bias_addr, bus.pix_index, bus.pix_chan);
        end
        bus.s_axis_tvalid = 1'b0;
        bias_exp = 0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        bus.CHANNEL_SIZE_choose = 2'd3; bus.IMAGE_SIZE_choose = 3'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.bias_addr !== 12'd0 || bus.conv_DONE !== 1'b0) begin failures++; $display("FAIL midreset_first_start busy=%b bias=%0d done=%b exp=1/0/0", bus.busy, bus.bias_addr, bus.conv_DONE); end
        drive_layer(32, 544, 543, 1'b0);
        drain(3);
        bias_exp++;
        checks++; if (done_cnt !== 1 || order_err !== 0 || bus.bias_addr !== 12'(bias_exp)) begin failures++; $display("FAIL midreset_rerun done=%0d order_err=%0d bias=%0d exp=1/0/%0d", done_cnt, order_err, bus.bias_addr, bias_exp); end
    endtask

    initial begin
        test_reset();
        test_full_layer();
        test_backpressure();
        test_tlast_early();
        test_tlast_missing();
        test_cfg_error();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_stream_scheduler.md
CONV_STREAM_SCHEDULER -- requirements
Module: conv_stream_scheduler

Interface
REQ-001 clk  in  1  sole clock; all state on rising edge.
REQ-002 aresetn  in  1  asynchronous, active-low reset for all state.
REQ-003 start  in  1  one-cycle request to run one output layer; sampled in IDLE only.
REQ-004 CHANNEL_SIZE_choose  in  2  channel count C: 0->256, 1->128, 2->64, 3->32.
REQ-005 IMAGE_SIZE_choose  in  3  image side N: 0->4, 1->8, 2->16, 3->32, 4->64; 5..7 invalid.
REQ-006 s_axis_tvalid, s_axis_tlast  in  1 each  upstream DMA stream qualifiers (256-bit data bypasses this block).
REQ-007 s_axis_tready  out  1  upstream ready.
REQ-008 pix_ready  in  1  datapath can accept an image beat.
REQ-009 out_last  in  1  datapath final output beat accepted (m_axis_tvalid & m_axis_tready & m_axis_tlast).
REQ-010 kernel_we  out  1  write strobe to kernel BRAM; kernel_addr  out  8  BRAM address.
REQ-011 pix_valid  out  1  image beat to datapath; pix_chan  out  8; pix_index  out  12 (row*N+col).
REQ-012 bias_addr  out  12  bias BRAM address, one per completed layer.
REQ-013 busy  out  1; conv_DONE  out  1 (one-cycle pulse); err_cfg, err_tlast_early, err_tlast_missing  out  1 each, sticky.

Function
REQ-014 States: IDLE, LOAD_KERNEL, STREAM_IMAGE, DRAIN, DONE; encoding free.
REQ-015 IDLE: start with valid IMAGE_SIZE_choose latches C and N, clears all err_* flags and beat counters, moves to LOAD_KERNEL next cycle.
REQ-016 IDLE: start with IMAGE_SIZE_choose 5..7 sets err_cfg, stays IDLE.
REQ-017 start outside IDLE is ignored; config inputs are not re-sampled mid-run.
REQ-018 Beat accepted = s_axis_tvalid & s_axis_tready in that cycle.
REQ-019 LOAD_KERNEL: s_axis_tready=1; each accepted beat: kernel_we=1, kernel_addr=k (k=0..C-1, combinational from counter); after beat C-1 -> STREAM_IMAGE.
REQ-020 STREAM_IMAGE: s_axis_tready=pix_ready (combinational); pix_valid=s_axis_tvalid & pix_ready.
REQ-021 Image beat order channel-fastest: beat b gives pix_chan=b mod C, pix_index=b div C; total N*N*C beats (20-bit counter, max 1,048,576).
REQ-022 Final image beat with s_axis_tlast=1 -> DRAIN; without tlast -> set err_tlast_missing, still DRAIN.
REQ-023 tlast on any accepted beat before the final image beat (including LOAD_KERNEL): set err_tlast_early, go to DRAIN immediately; remaining beats are not requested.
REQ-024 DRAIN: s_axis_tready=0; wait for out_last; -> DONE. After an early-tlast abort, DRAIN exits to DONE on next cycle without waiting.
REQ-025 DONE: conv_DONE=1 for exactly one cycle, bias_addr increments by 1 (wraps 4095->0), -> IDLE.
REQ-026 busy=1 in every state except IDLE.
REQ-027 kernel_we, pix_valid only asserted on accepted beats; never both in same cycle.
REQ-028 s_axis_tready=0 in IDLE, DRAIN, DONE.
REQ-029 No latency from stream handshake to kernel_we/pix_valid (same cycle).

Reset
REQ-030 aresetn low, any state: state=IDLE, all counters 0, bias_addr=0, all outputs 0, err flags cleared; effective asynchronously.
REQ-031 Reset mid-run abandons the layer; no conv_DONE, bias_addr not incremented after release.
REQ-032 First start accepted on first rising edge after aresetn deasserts.

Verification
REQ-033 C=256,N=4, 4352 beats, tlast on last, pix_ready=1, out_last pulsed 20 cycles later -> 256 kernel_we (addr 0..255), 4096 pix_valid, last pix_index=15 pix_chan=255, one conv_DONE, bias_addr=1, no errors.
REQ-034 C=32,N=8, pix_ready toggling every other cycle -> s_axis_tready mirrors pix_ready in STREAM_IMAGE, exactly 2048 pix_valid, no beat lost or duplicated.
REQ-035 tlast on kernel beat 10 (C=256) -> err_tlast_early=1, s_axis_tready=0 from next cycle, conv_DONE two cycles later, bias_addr=1.
REQ-036 C=128,N=4, no tlast on beat 2175 -> err_tlast_missing=1, DRAIN waits for out_last, then conv_DONE.
REQ-037 start with IMAGE_SIZE_choose=6 -> err_cfg=1, busy=0; next start with 0 clears err_cfg and runs.
REQ-038 aresetn low during STREAM_IMAGE beat 100 -> all outputs 0, busy=0, bias_addr=0; new run completes normally.
